// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encoding constants for the instruction loader and the CPU decoder:
// major opcodes, funct3/funct7 values, field bit positions, loader op-select
// codes, the canonical NOP word and the loader state type.
package instr_encoder_loader_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 / funct7
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Field LSB positions within the 32-bit word
    localparam int OPC_LSB   = 0;
    localparam int RD_LSB    = 7;
    localparam int IMMS_LSB  = 7;
    localparam int F3_LSB    = 12;
    localparam int IMMU_LSB  = 12;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int IMMI_LSB  = 20;
    localparam int F7_LSB    = 25;
    localparam int IMMSH_LSB = 25;

    // Loader op-select codes (6 and 7 are illegal)
    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_LW   = 3'd2;
    localparam logic [2:0] SEL_SW   = 3'd3;
    localparam logic [2:0] SEL_ADDI = 3'd4;
    localparam logic [2:0] SEL_LUI  = 3'd5;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1,
        ST_PAD  = 2'd2
    } load_state_e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        logic [31:0] w;
        w = '0;
        w[F7_LSB  +: 7] = f7;
        w[RS2_LSB +: 5] = rs2;
        w[RS1_LSB +: 5] = rs1;
        w[F3_LSB  +: 3] = f3;
        w[RD_LSB  +: 5] = rd;
        w[OPC_LSB +: 7] = opc;
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        logic [31:0] w;
        w = '0;
        w[IMMI_LSB +: 12] = imm;
        w[RS1_LSB  +: 5]  = rs1;
        w[F3_LSB   +: 3]  = f3;
        w[RD_LSB   +: 5]  = rd;
        w[OPC_LSB  +: 7]  = opc;
        return w;
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        logic [31:0] w;
        w = '0;
        w[IMMSH_LSB +: 7] = imm[11:5];
        w[RS2_LSB   +: 5] = rs2;
        w[RS1_LSB   +: 5] = rs1;
        w[F3_LSB    +: 3] = f3;
        w[IMMS_LSB  +: 5] = imm[4:0];
        w[OPC_LSB   +: 7] = opc;
        return w;
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        logic [31:0] w;
        w = '0;
        w[IMMU_LSB +: 20] = imm;
        w[RD_LSB   +: 5]  = rd;
        w[OPC_LSB  +: 7]  = opc;
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_field_packer.sv
// Combinational packer: loader op select plus register/immediate fields into
// one RV32I word. Fields an op does not use are left at zero.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [19:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Pick the instruction format for the op; unknown selects flag illegal
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            SEL_ADD:  word = enc_r(F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP);
            SEL_SUB:  word = enc_r(F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP);
            SEL_LW:   word = enc_i(imm[11:0], rs1, F3_WORD, rd, OPC_LOAD);
            SEL_SW:   word = enc_s(imm[11:0], rs2, rs1, F3_WORD, OPC_STORE);
            SEL_ADDI: word = enc_i(imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM);
            SEL_LUI:  word = enc_u(imm, rd, OPC_LUI);
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts field-level requests, encodes them to
// RV32I words and writes them sequentially into imem, one word per cycle.
// Optional build macro INSTR_ENC_NOP_PAD_EN: when defined, finishing a program
// fills the remaining imem words with NOPs before reporting done.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [19:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal
);

    // word_count doubles as the write pointer; it stops at capacity, so the
    // pointer never wraps.
    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    load_state_e state;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        accept;
    logic        at_last_slot;
    logic        finish_run;

    instr_field_packer u_packer (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready     = (state == ST_RUN) && !clear;
    assign accept       = in_valid && in_ready;
    assign at_last_slot = (word_count == LAST_SLOT);
    assign finish_run   = in_last || (!enc_illegal && at_last_slot);

    // Loader FSM with registered write port, counters and status flags
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ST_RUN;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (enc_illegal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[ADDR_W-1:0];
                            imem_wdata <= enc_word;
                            word_count <= word_count + ONE;
                        end
                        if (finish_run) begin
`ifdef INSTR_ENC_NOP_PAD_EN
                            // Padding starts at the next free slot; skip it if
                            // this write takes the final slot.
                            if (!enc_illegal && at_last_slot) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_PAD;
                            end
`else
                            state <= ST_DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef INSTR_ENC_NOP_PAD_EN
                ST_PAD: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_count[ADDR_W-1:0];
                    imem_wdata <= NOP_WORD;
                    word_count <= word_count + ONE;
                    if (at_last_slot) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    // DONE holds until rst or clear
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes field-level instruction requests (op select, rd, rs1, rs2, imm) into 32-bit RV32I words for the CPU's supported subset: ADD, SUB, LW, SW, ADDI, LUI.
- Writes encoded words sequentially into instruction memory through a write port.
- Sits between the test/boot host and the imem; it is the producer side of the instruction format the CPU decodes.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clear  input  1  one-cycle pulse; restarts loading at address 0
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_op  input  3  0=ADD 1=SUB 2=LW 3=SW 4=ADDI 5=LUI; 6 and 7 are illegal
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  20  immediate; [11:0] for LW/SW/ADDI, [19:0] for LUI
- in_last  input  1  final instruction of the program
- imem_we  output  1  imem write strobe
- imem_addr  output  ADDR_W  imem word address
- imem_wdata  output  32  encoded instruction
- word_count  output  ADDR_W+1  words written since reset/clear
- done  output  1  loading finished
- err_illegal  output  1  sticky flag; an illegal op was received

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. Every state and output register updates only on the rising edge of clk.
- Reset values: state=RUN, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, done=0, err_illegal=0. A pending write is dropped.
- States: RUN, DONE (plus PAD when the optional feature is enabled).
- in_ready = (state==RUN) && !clear. A request is accepted on a rising edge where in_valid && in_ready.
- Latency: an accepted legal op drives imem_we=1, imem_wdata=encoded word and imem_addr=current write pointer in the cycle after acceptance. It then increments the pointer and word_count. Back-to-back accepts give one write per cycle. imem_we=0 whenever no write is pending.
- Encoding (standard RV32I, fields unused by an op forced to 0):
  - ADD: {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}
  - SUB: {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
  - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}
  - LUI: {imm[19:0], rd, 7'b0110111}
- Illegal op (6 or 7): the request is accepted but no write occurs, the pointer does not advance, and err_illegal is set (sticky until rst or clear).
- in_last on an accepted request: RUN→DONE after that request's write (or immediately if the op is illegal).
- Full: accepting a legal op at pointer 2**ADDR_W-1 writes it, then RUN→DONE. The pointer never wraps. word_count saturates at 2**ADDR_W.
- DONE: done=1, in_ready=0. The block holds until rst or clear.
- clear: has the same effect as rst, except that the clear input is sampled. When clear and in_valid coincide, clear wins and the request is not accepted.

Optional Feature:
- Macro: INSTR_ENC_NOP_PAD_EN.
- Defined: every RUN→DONE transition passes through PAD. PAD writes NOP 0x00000013 once per cycle at successive addresses through 2**ADDR_W-1, then enters DONE. in_ready=0 and done=0 during PAD, and word_count counts the pad words. If the last legal write already filled the memory, PAD is skipped.
- Not defined: no PAD state; RUN goes directly to DONE.

Decomposition:
- Shared package/include: opcode constants (R/I/S/IMM/LUI opcodes), funct3/funct7 constants, field bit ranges, in_op select codes, NOP word constant. These are shared with the CPU decoder.
- Sub-module instr_field_packer: combinational in_op/fields → 32-bit word plus an illegal flag. The FSM, pointer and write registers stay in the top module.

Test Plan:
- ADD rd=3 rs1=1 rs2=2, then SUB rd=5 rs1=6 rs2=7, back-to-back → writes 0x002081B3 @0 and 0x407302B3 @1 on consecutive cycles; word_count=2.
- LW rd=4 rs1=2 imm=8; SW rs1=2 rs2=5 imm=12; ADDI rd=1 rs1=0 imm=0xFFF; LUI rd=7 imm=0x12345 (in_last on the LUI) → 0x00812203, 0x00512623, 0xFFF00093, 0x123453B7 @0..3; done=1, in_ready=0.
- in_op=6 between two ADDs → err_illegal=1; only 2 writes, at addresses 0 and 1.
- ADDR_W=2: stream 5 ADDIs → 4 writes @0..3, done after the 4th, 5th not accepted (in_ready=0); word_count=4.
- rst asserted the cycle after an accept → no imem_we, all outputs reset, in_ready=1 next cycle; clear in DONE → addr 0, done=0, err_illegal=0.
- With INSTR_ENC_NOP_PAD_EN, ADDR_W=3, 2 ops then in_last → addresses 2..7 written with 0x00000013, then done=1, word_count=8.
